braille_digit_scroller: RTL

Captures Braille cells from a six-dot switch input and stores them in a DEPTH-entry buffer. Each cell is committed by a debounced push-button and decoded as a Braille numeral (a–j → 1–9, 0). The newest DIGITS entries are driven onto a time-multiplexed common 7-segment display. It is the sequential, parametrised successor to the two-digit combinational Braille-to-7-segment top. It sits between the board's switch/button inputs and the display pins.

---
 rtl/braille_digit_scroller.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/braille_digit_scroller.sv
// Braille numeral capture buffer with debounced commit and a time-multiplexed
// 7-segment display showing the newest DIGITS entries (entry 0 rightmost).
module braille_digit_scroller #(
  parameter int DIGITS   = 2,
  parameter int DEPTH    = 8,
  parameter int DEBOUNCE = 4,
  parameter int SCAN_DIV = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [5:0]                   dots,
  input  logic                         commit,
  input  logic                         clear,
  output logic [6:0]                   seg,
  output logic [DIGITS-1:0]            an,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, HELD = 2'd2} state_t;

  // Returns {valid, code}; code 4'hF is the blank/space cell.
  function automatic logic [4:0] decode_dots(input logic [5:0] d);
    case (d)
      6'h01:   return {1'b1, 4'd1};
      6'h03:   return {1'b1, 4'd2};
      6'h09:   return {1'b1, 4'd3};
      6'h19:   return {1'b1, 4'd4};
      6'h11:   return {1'b1, 4'd5};
      6'h0B:   return {1'b1, 4'd6};
      6'h1B:   return {1'b1, 4'd7};
      6'h13:   return {1'b1, 4'd8};
      6'h0A:   return {1'b1, 4'd9};
      6'h1A:   return {1'b1, 4'd0};
      6'h00:   return {1'b1, 4'hF};
      default: return {1'b0, 4'hF};
    endcase
  endfunction

  function automatic logic [6:0] seg_pattern(input logic [3:0] c);
    case (c)
      4'd0:    return 7'h7E;
      4'd1:    return 7'h30;
      4'd2:    return 7'h6D;
      4'd3:    return 7'h79;
      4'd4:    return 7'h33;
      4'd5:    return 7'h5B;
      4'd6:    return 7'h5F;
      4'd7:    return 7'h70;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

  logic [5:0]          dots_s1_r, dots_s2_r;
  logic                commit_s1_r, commit_s2_r;
  logic                clear_s1_r, clear_s2_r;
  state_t              state_r;
  logic [DW-1:0]       deb_cnt_r;
  logic                push_s;
  logic [4:0]          dec_s;
  logic [3:0]          entry_r [DEPTH];
  logic [CW-1:0]       count_r;
  logic                full_r;
  logic                err_r;
  logic [SW-1:0]       scan_cnt_r, scan_nxt_s;
  logic [IW-1:0]       idx_r, idx_nxt_s;
  logic [3:0]          sel_code_s;
  logic [6:0]          seg_r, seg_nxt_s;
  logic [DIGITS-1:0]   an_r;

  // Two-flop synchronisers for all asynchronous inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dots_s1_r   <= 6'h00;
      dots_s2_r   <= 6'h00;
      commit_s1_r <= 1'b0;
      commit_s2_r <= 1'b0;
      clear_s1_r  <= 1'b0;
      clear_s2_r  <= 1'b0;
    end else begin
      dots_s1_r   <= dots;
      dots_s2_r   <= dots_s1_r;
      commit_s1_r <= commit;
      commit_s2_r <= commit_s1_r;
      clear_s1_r  <= clear;
      clear_s2_r  <= clear_s1_r;
    end
  end

  // Push fires on the edge the FSM leaves COUNT for HELD.
  always_comb begin
    push_s = (state_r == COUNT) && commit_s2_r && (deb_cnt_r == DW'(DEBOUNCE));
    dec_s  = decode_dots(dots_s2_r);
  end

  // Commit debounce FSM: one push per press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      deb_cnt_r <= '0;
    end else if (clear_s2_r) begin
      state_r   <= IDLE;
      deb_cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (commit_s2_r) begin
            state_r   <= COUNT;
            deb_cnt_r <= DW'(1'b1);
          end else begin
            deb_cnt_r <= '0;
          end
        end
        COUNT: begin
          if (!commit_s2_r) begin
            state_r   <= IDLE;
            deb_cnt_r <= '0;
          end else if (deb_cnt_r == DW'(DEBOUNCE)) begin
            state_r <= HELD;
          end else begin
            deb_cnt_r <= deb_cnt_r + DW'(1'b1);
          end
        end
        HELD: begin
          if (!commit_s2_r) begin
            state_r   <= IDLE;
            deb_cnt_r <= '0;
          end
        end
        default: begin
          state_r   <= IDLE;
          deb_cnt_r <= '0;
        end
      endcase
    end
  end

  // Shift buffer, occupancy and sticky error; clear overrides a push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) entry_r[k] <= 4'hF;
      count_r <= '0;
      full_r  <= 1'b0;
      err_r   <= 1'b0;
    end else if (clear_s2_r) begin
      for (int k = 0; k < DEPTH; k++) entry_r[k] <= 4'hF;
      count_r <= '0;
      full_r  <= 1'b0;
      err_r   <= 1'b0;
    end else if (push_s) begin
      if (!dec_s[4] || (count_r == CW'(DEPTH))) begin
        err_r <= 1'b1;
      end else begin
        entry_r[0] <= dec_s[3:0];
        for (int k = 1; k < DEPTH; k++) entry_r[k] <= entry_r[k-1];
        count_r <= count_r + CW'(1'b1);
        full_r  <= ((count_r + CW'(1'b1)) == CW'(DEPTH));
      end
    end
  end

  // Next scan position and the segment pattern for that digit.
  always_comb begin
    if (scan_cnt_r == SW'(SCAN_DIV - 1)) begin
      scan_nxt_s = '0;
      if (idx_r == IW'(DIGITS - 1)) begin
        idx_nxt_s = '0;
      end else begin
        idx_nxt_s = idx_r + IW'(1'b1);
      end
    end else begin
      scan_nxt_s = scan_cnt_r + SW'(1'b1);
      idx_nxt_s  = idx_r;
    end
    sel_code_s = 4'hF;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_nxt_s == IW'(k)) begin
        sel_code_s = entry_r[k];
      end else begin
        sel_code_s = sel_code_s;
      end
    end
    if (32'(idx_nxt_s) < 32'(count_r)) begin
      seg_nxt_s = seg_pattern(sel_code_s);
    end else begin
      seg_nxt_s = 7'h00;
    end
  end

  // Registered scan state so seg and an move on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_r <= '0;
      idx_r      <= '0;
      seg_r      <= 7'h00;
      an_r       <= DIGITS'(1'b1);
    end else begin
      scan_cnt_r <= scan_nxt_s;
      idx_r      <= idx_nxt_s;
      seg_r      <= seg_nxt_s;
      an_r       <= DIGITS'(1'b1) << idx_nxt_s;
    end
  end

  assign seg   = seg_r;
  assign an    = an_r;
  assign count = count_r;
  assign full  = full_r;
  assign err   = err_r;

endmodule
